edge_detect_multi: RTL

- Parametrised multi-channel edge detector for asynchronous inputs such as buttons, external strobes and interrupt lines.
- Each channel has a synchroniser chain, a consecutive-sample glitch filter, runtime-selectable edge mode, a registered one-cycle flag, a sticky flag and a saturating edge counter.
- Sits between top-level async inputs and interrupt/status logic.

---
 rtl/edge_detect_multi.sv | 124 ++++++++++++
 1 files changed

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: sync chain, glitch filter, edge select,
// one-cycle flag, sticky flag and saturating edge counter per channel.
module edge_detect_multi #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       din,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       clr,
    output logic [WIDTH-1:0]       flag,
    output logic                   any_flag,
    output logic [WIDTH-1:0]       sticky,
    output logic [WIDTH*CNT_W-1:0] edge_cnt
);

    localparam int FC_W =
        (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LAST =
        FC_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] flag_nxt;
    logic [CNT_W-1:0] cnt_r [WIDTH];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++)
                sync_r[k] <= '0;
        end else begin
            sync_r[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync_r[k] <= sync_r[k-1];
        end
    end

    assign s = sync_r[SYNC_STAGES-1];

    // The filter counts consecutive disagreeing samples; any agreeing
    // sample restarts the count so short pulses never reach q.
    for (genvar i = 0; i < WIDTH; i++) begin : g_filt
        logic [FC_W-1:0] fc;

        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n) begin
                fc   <= '0;
                q[i] <= 1'b0;
            end else if (s[i] == q[i]) begin
                fc <= '0;
            end else if (fc == FC_LAST) begin
                fc   <= '0;
                q[i] <= s[i];
            end else begin
                fc <= fc + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            q_prev <= '0;
        else
            q_prev <= q;
    end

    assign rise = q & ~q_prev;
    assign fall = ~q & q_prev;

    always_comb begin
        flag_nxt = '0;
        unique case (mode)
            MODE_RISE: flag_nxt = rise;
            MODE_FALL: flag_nxt = fall;
            MODE_BOTH: flag_nxt = rise | fall;
            MODE_OFF:  flag_nxt = '0;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            flag     <= '0;
            any_flag <= 1'b0;
        end else begin
            flag     <= flag_nxt;
            any_flag <= |flag_nxt;
        end
    end

    // A clear coinciding with a flag keeps the new event.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            sticky <= '0;
        else
            sticky <= flag | (sticky & ~clr);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cnt
        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n)
                cnt_r[i] <= '0;
            else if (clr[i])
                cnt_r[i] <= flag[i] ? CNT_ONE : '0;
            else if (flag[i] && !(&cnt_r[i]))
                cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end

        assign edge_cnt[i*CNT_W +: CNT_W] = cnt_r[i];
    end

endmodule
